pb_event_arbiter: RTL and testbench

Collects release events from N_PB board push buttons and hands them one at a time to the mode/config logic over a valid/ready handshake. Each button is synchronized, debounced and release-detected, then queued as a pending flag. A round-robin arbiter shares the single event port between buttons so that no button can starve another. The block sits between the board pins and the control-mode FSM.

---
 rtl/pb_event_arbiter.sv | 124 ++++++++++++
 tb/tb_pb_event_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_event_arbiter.sv
// Push-button release collector: sync, debounce, release detect, pending
// flags and a round-robin arbiter onto a single valid/ready event port.
module pb_event_arbiter #(
    parameter int N_PB         = 4,
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_PB-1:0]         PB,
    output logic                    evt_valid,
    output logic [$clog2(N_PB)-1:0] evt_id,
    input  logic                    evt_ready,
    output logic [N_PB-1:0]         btn_state,
    output logic [N_PB-1:0]         ovr,
    input  logic                    ovr_clr
);

    localparam int IDW = $clog2(N_PB);
    localparam int CW  = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t          state, state_n;
    logic [N_PB-1:0] s1, s2, stable;
    logic [CW-1:0]   cnt [N_PB];
    logic [N_PB-1:0] rise, clr;
    logic [N_PB-1:0] pending, pending_n, ovr_n;
    logic [IDW-1:0]  ptr, ptr_n, id_n, pick;
    logic            found;
    int              j;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= '1;
            s2     <= '1;
            stable <= '1;
            for (int i = 0; i < N_PB; i++) cnt[i] <= '0;
        end else begin
            s1 <= PB;
            s2 <= s1;
            for (int i = 0; i < N_PB; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // A release is the debounced level being accepted as 0->1 on this edge.
    always_comb begin
        rise = '0;
        for (int i = 0; i < N_PB; i++)
            rise[i] = ~stable[i] & s2[i] & (cnt[i] == CNT_MAX);
    end

    // Lowest offset from ptr wins, so scan offsets from high to low.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        j     = 0;
        for (int k = N_PB - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_PB;
            if (pending[IDW'(j)]) begin
                found = 1'b1;
                pick  = IDW'(j);
            end
        end
    end

    always_comb begin
        state_n = state;
        id_n    = evt_id;
        ptr_n   = ptr;
        clr     = '0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = OFFER;
                    id_n    = pick;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    state_n     = IDLE;
                    clr[evt_id] = 1'b1;
                    ptr_n       = (evt_id == IDW'(N_PB - 1)) ? '0 : evt_id + 1'b1;
                end
            end
        endcase
    end

    // A release coinciding with its own accept re-queues instead of overrunning.
    assign pending_n = (pending & ~clr) | rise;
    assign ovr_n     = (ovr_clr ? '0 : ovr) | (rise & pending & ~clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            evt_id  <= '0;
            ptr     <= '0;
            pending <= '0;
            ovr     <= '0;
        end else begin
            state   <= state_n;
            evt_id  <= id_n;
            ptr     <= ptr_n;
            pending <= pending_n;
            ovr     <= ovr_n;
        end
    end

    assign evt_valid = (state == OFFER);
    assign btn_state = stable;

endmodule

// File: tb/tb_pb_event_arbiter.sv
// Self-checking bench for pb_event_arbiter: directed scenarios plus a
// randomized run against a window-based behavioural model.
module tb_pb_event_arbiter;

    localparam int N   = 4;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] PB = '1;
    logic         evt_valid;
    logic [1:0]   evt_id;
    logic         evt_ready = 1'b0;
    logic [N-1:0] btn_state;
    logic [N-1:0] ovr;
    logic         ovr_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [N-1:0] hist[$];
    logic [N-1:0] mstable, mpend, movr;
    bit           mbusy;
    int           mid, mptr;
    int           acc_ids[$];

    pb_event_arbiter #(
        .N_PB(N),
        .DEBOUNCE_CYC(DEB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .PB(PB),
        .evt_valid(evt_valid),
        .evt_id(evt_id),
        .evt_ready(evt_ready),
        .btn_state(btn_state),
        .ovr(ovr),
        .ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic mreset();
        hist.delete();
        repeat (DEB + 2) hist.push_front('1);
        mstable = '1;
        mpend   = '0;
        movr    = '0;
        mbusy   = 1'b0;
        mid     = 0;
        mptr    = 0;
    endtask

    // Level accepted once the synchronized pin (2 edges late) has differed
    // from the debounced level on DEB consecutive edges.
    task automatic model_step();
        logic [N-1:0] rise, clrm;
        bit acc, found, diff;
        int pick, idx;
        if (!rst_n) begin
            mreset();
            return;
        end
        hist.push_front(PB);
        while (hist.size() > DEB + 2) void'(hist.pop_back());
        rise = '0;
        for (int i = 0; i < N; i++) begin
            diff = 1'b1;
            for (int k = 2; k < DEB + 2; k++)
                if (hist[k][i] == mstable[i]) diff = 1'b0;
            if (diff) begin
                if (!mstable[i]) rise[i] = 1'b1;
                mstable[i] = ~mstable[i];
            end
        end
        acc = mbusy && evt_ready;
        found = 1'b0;
        pick = 0;
        for (int k = 0; k < N; k++) begin
            idx = (mptr + k) % N;
            if (!found && mpend[idx]) begin
                found = 1'b1;
                pick = idx;
            end
        end
        clrm = acc ? (N'(1) << mid) : '0;
        movr = (ovr_clr ? '0 : movr) | (rise & mpend & ~clrm);
        mpend = (mpend & ~clrm) | rise;
        if (acc) begin
            mptr = (mid + 1) % N;
            mbusy = 1'b0;
        end else if (!mbusy && found) begin
            mbusy = 1'b1;
            mid = pick;
        end
    endtask

    task automatic cyc();
        if (evt_valid === 1'b1 && evt_ready) acc_ids.push_back(int'(evt_id));
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit saw_valid;
        rst_n = 1'b0;
        repeat (3) cyc();
        checks++;
        if (evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", evt_valid);
        end
        checks++;
        if (evt_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_id got=%0d exp=0", evt_id);
        end
        checks++;
        if (btn_state !== 4'hf || ovr !== 4'h0) begin
            failures++;
            $display("FAIL reset_levels btn=%h ovr=%h exp f/0", btn_state, ovr);
        end
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (100) begin
            cyc();
            if (evt_valid !== 1'b0) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid || ovr !== 4'h0 || btn_state !== 4'hf) begin
            failures++;
            $display("FAIL idle_100 valid_seen=%b ovr=%h btn=%h exp 0/0/f",
                     saw_valid, ovr, btn_state);
        end
    endtask

    task automatic test_release();
        acc_ids.delete();
        evt_ready = 1'b1;
        PB[1] = 1'b0;
        repeat (20) cyc();
        PB[1] = 1'b1;
        repeat (5) cyc();
        checks++;
        if (btn_state[1] !== 1'b0) begin
            failures++;
            $display("FAIL rel_early btn1=%b exp=0", btn_state[1]);
        end
        cyc();
        checks++;
        if (btn_state[1] !== 1'b1 || evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL rel_edge6 btn1=%b valid=%b exp 1/0", btn_state[1], evt_valid);
        end
        cyc();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
            failures++;
            $display("FAIL rel_offer valid=%b id=%0d exp 1/1", evt_valid, evt_id);
        end
        repeat (20) cyc();
        checks++;
        if (acc_ids.size() != 1 || acc_ids[0] != 1) begin
            failures++;
            $display("FAIL rel_count n=%0d exp=1 id1", acc_ids.size());
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_bounce();
        int n_fall, n_rise;
        logic prev;
        acc_ids.delete();
        evt_ready = 1'b1;
        n_fall = 0;
        n_rise = 0;
        prev = btn_state[0];
        for (int c = 0; c < 110; c++) begin
            if (c < 30) PB[0] = ((c / 2) % 2) != 0;
            else if (c < 45) PB[0] = 1'b0;
            else if (c < 75) PB[0] = (((c - 45) / 2) % 2) == 0;
            else PB[0] = 1'b1;
            cyc();
            if (prev && !btn_state[0]) n_fall++;
            if (!prev && btn_state[0]) n_rise++;
            prev = btn_state[0];
        end
        checks++;
        if (n_fall != 1 || n_rise != 1) begin
            failures++;
            $display("FAIL bounce_edges falls=%0d rises=%0d exp 1/1", n_fall, n_rise);
        end
        checks++;
        if (acc_ids.size() != 1 || acc_ids[0] != 0) begin
            failures++;
            $display("FAIL bounce_events n=%0d exp=1 id0", acc_ids.size());
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_ids[4] = '{0, 2, 3, 0};
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        acc_ids.delete();
        evt_ready = 1'b0;
        PB = 4'b0010;
        repeat (10) cyc();
        PB = 4'b1111;
        for (int e = 0; e < 4; e++) begin
            for (int c = 0; c < 20 && evt_valid !== 1'b1; c++) cyc();
            if (e == 2) begin
                PB[0] = 1'b0;
                repeat (10) cyc();
                PB[0] = 1'b1;
                repeat (10) cyc();
            end
            checks++;
            if (evt_valid !== 1'b1 || evt_id !== 2'(exp_ids[e])) begin
                failures++;
                $display("FAIL rr_offer%0d valid=%b id=%0d exp 1/%0d",
                         e, evt_valid, evt_id, exp_ids[e]);
            end
            evt_ready = 1'b1;
            cyc();
            evt_ready = 1'b0;
        end
        repeat (10) cyc();
        checks++;
        if (evt_valid !== 1'b0 || acc_ids.size() != 4) begin
            failures++;
            $display("FAIL rr_drain valid=%b n=%0d exp 0/4", evt_valid, acc_ids.size());
        end
    endtask

    task automatic test_backpressure();
        acc_ids.delete();
        evt_ready = 1'b0;
        PB[2] = 1'b0;
        repeat (10) cyc();
        PB[2] = 1'b1;
        for (int c = 0; c < 20 && evt_valid !== 1'b1; c++) cyc();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd2 || ovr !== 4'h0) begin
            failures++;
            $display("FAIL bp_offer valid=%b id=%0d ovr=%h exp 1/2/0",
                     evt_valid, evt_id, ovr);
        end
        PB[2] = 1'b0;
        repeat (10) cyc();
        PB[2] = 1'b1;
        repeat (10) cyc();
        checks++;
        if (ovr !== 4'b0100 || evt_id !== 2'd2 || evt_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_overrun ovr=%h id=%0d valid=%b exp 4/2/1",
                     ovr, evt_id, evt_valid);
        end
        evt_ready = 1'b1;
        repeat (10) cyc();
        evt_ready = 1'b0;
        checks++;
        if (acc_ids.size() != 1 || ovr !== 4'b0100) begin
            failures++;
            $display("FAIL bp_single n=%0d ovr=%h exp 1/4", acc_ids.size(), ovr);
        end
        ovr_clr = 1'b1;
        cyc();
        ovr_clr = 1'b0;
        checks++;
        if (ovr !== 4'h0) begin
            failures++;
            $display("FAIL bp_clear ovr=%h exp=0", ovr);
        end
    endtask

    task automatic test_coincide();
        acc_ids.delete();
        evt_ready = 1'b0;
        PB[1] = 1'b0;
        repeat (10) cyc();
        PB[1] = 1'b1;
        for (int c = 0; c < 20 && evt_valid !== 1'b1; c++) cyc();
        PB[1] = 1'b0;
        repeat (10) cyc();
        PB[1] = 1'b1;
        repeat (5) cyc();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd1 || btn_state[1] !== 1'b0) begin
            failures++;
            $display("FAIL co_setup valid=%b id=%0d btn1=%b exp 1/1/0",
                     evt_valid, evt_id, btn_state[1]);
        end
        evt_ready = 1'b1;
        cyc();
        evt_ready = 1'b0;
        checks++;
        if (btn_state[1] !== 1'b1 || evt_valid !== 1'b0 || ovr[1] !== 1'b0) begin
            failures++;
            $display("FAIL co_edge btn1=%b valid=%b ovr1=%b exp 1/0/0",
                     btn_state[1], evt_valid, ovr[1]);
        end
        cyc();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
            failures++;
            $display("FAIL co_second valid=%b id=%0d exp 1/1", evt_valid, evt_id);
        end
        evt_ready = 1'b1;
        cyc();
        evt_ready = 1'b0;
        repeat (5) cyc();
        checks++;
        if (acc_ids.size() != 2 || evt_valid !== 1'b0 || ovr !== 4'h0) begin
            failures++;
            $display("FAIL co_count n=%0d valid=%b ovr=%h exp 2/0/0",
                     acc_ids.size(), evt_valid, ovr);
        end
    endtask

    task automatic test_async_reset();
        bit saw_valid;
        evt_ready = 1'b0;
        PB[3] = 1'b0;
        repeat (10) cyc();
        PB[3] = 1'b1;
        for (int c = 0; c < 20 && evt_valid !== 1'b1; c++) cyc();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin
            failures++;
            $display("FAIL ar_offer valid=%b id=%0d exp 1/3", evt_valid, evt_id);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (evt_valid !== 1'b0 || evt_id !== 2'd0) begin
            failures++;
            $display("FAIL ar_drop valid=%b id=%0d exp 0/0", evt_valid, evt_id);
        end
        mreset();
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (10) begin
            cyc();
            if (evt_valid !== 1'b0) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid) begin
            failures++;
            $display("FAIL ar_after valid_seen=%b exp=0", saw_valid);
        end
    endtask

    task automatic test_random();
        int hold[N];
        int bad;
        bad = 0;
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    PB[i] = 1'($urandom_range(0, 1));
                    hold[i] = $urandom_range(1, 10);
                end else begin
                    hold[i]--;
                end
            end
            evt_ready = (c < 1500) ? ($urandom_range(0, 3) != 0)
                                   : ($urandom_range(0, 4) == 0);
            ovr_clr = ($urandom_range(0, 40) == 0);
            cyc();
            checks++;
            if (btn_state !== mstable || ovr !== movr || evt_valid !== mbusy ||
                (mbusy && evt_id !== 2'(mid))) begin
                failures++;
                if (bad < 10)
                    $display("FAIL rand_c%0d btn=%h/%h ovr=%h/%h valid=%b/%b id=%0d/%0d",
                             c, btn_state, mstable, ovr, movr, evt_valid, mbusy,
                             evt_id, mid);
                bad++;
            end
        end
        evt_ready = 1'b0;
        ovr_clr = 1'b0;
        PB = '1;
    endtask

    initial begin
        mreset();
        test_reset();
        test_release();
        test_bounce();
        test_round_robin();
        test_backpressure();
        test_coincide();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
